noc_result_drain: RTL and testbench
===================================

Name: noc_result_drain

Overview:
- Downstream consumer of the PE-array NoC; captures each flat result frame when the NoC pulses ready, together with its per-PE visible mask.
- Buffers up to FRAME_DEPTH frames and drains them row by row over a valid/ready stream to the writeback/output memory stage.
- Rows with no visible PE are skipped, and non-visible lanes are zeroed.

Parameters:
- DATA_WIDTH, 8, bits per PE result lane.
- NUM_PEs_PER_ROW, 4, PE lanes per row; equals lanes per output beat.
- NUM_ROWS, 4, PE rows per frame.
- FRAME_DEPTH, 2, frame buffer depth; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- noc_result  in  NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH  flat NoC result; row r at [r*NUM_PEs_PER_ROW*DATA_WIDTH +: NUM_PEs_PER_ROW*DATA_WIDTH], lane p within a row at [p*DATA_WIDTH +: DATA_WIDTH].
- noc_ready  in  1  frame-valid strobe from the NoC; each high cycle is one frame.
- visible  in  NUM_ROWS*NUM_PEs_PER_ROW  per-PE visible mask, sampled with noc_ready; bit r*NUM_PEs_PER_ROW+p.
- out_data  out  NUM_PEs_PER_ROW*DATA_WIDTH  row beat; invisible lanes forced to 0.
- out_mask  out  NUM_PEs_PER_ROW  visible bits of the emitted row.
- out_row  out  max(1,$clog2(NUM_ROWS))  row index of the beat.
- out_last  out  1  high on the last visible row of the frame.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- overflow  out  1  sticky: a frame was dropped.
- busy  out  1  high when the buffer is non-empty or a beat is pending.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FIFO pointers and count 0, FSM in IDLE, overflow 0. Buffered frames are discarded, including one mid-drain. out_valid deasserts immediately.
- Capture: on a rising edge with noc_ready=1 and the FIFO not full, write {noc_result, visible} at the write pointer; count increments.
- If the FIFO is full and no pop occurs in the same cycle, the frame is dropped, overflow is set to 1 and held until reset. Buffer contents are unaffected.
- Simultaneous capture and pop while full: the pop frees a slot and the capture is accepted with no overflow.
- Back-to-back noc_ready pulses in consecutive cycles are each captured as separate frames while space remains.
- Pointers wrap modulo FRAME_DEPTH. Full = (count == FRAME_DEPTH).
- FSM has three states:
  - IDLE: if count>0, go to SCAN with row=0.
  - SCAN: evaluates one row per cycle.
    - If the head frame's row mask is non-zero, present the beat and go to SEND.
    - Otherwise row++.
    - If no visible row remains (including an all-zero frame), pop the frame silently and return to IDLE. No beat is emitted.
  - SEND: out_valid=1.
    - out_data/out_mask/out_row/out_last stay stable until out_valid && out_ready.
    - On acceptance with out_last=1: pop the frame and go to IDLE.
    - Otherwise: row++ and go to SCAN.
- out_last is computed combinationally from the remaining rows' masks: high when no higher row of the frame has a visible bit.
- Latency:
  - Capture edge T: SCAN evaluates at T+1, so out_valid can rise at T+2 for a frame whose row 0 is visible.
  - Each skipped row adds 1 cycle.
  - Sustained throughput is 1 beat per 2 cycles.
- out_valid never drops without a handshake, except on reset.
- busy = (count != 0) | out_valid.

Test Plan:
- Reset, single frame: after reset release, pulse noc_ready with lane (r,p) = 16r+p and visible=16'hFFFF. Expect 4 beats, out_row 0..3; row 1 out_data=32'h13121110; out_last only on row 3; busy returns to 0.
- Masking/skip: visible=16'h0F0A (row0 mask 4'hA, row1 0, row2 4'hF, row3 0). Expect 2 beats: row0 with lanes 0 and 2 zeroed, then row2 with out_last=1.
- All-invisible frame: visible=0. Expect no out_valid; frame popped within 5 cycles; the next frame drains normally.
- Backpressure: hold out_ready=0 for 10 cycles while out_valid=1. Expect out_data and out_row stable, with no beat lost or duplicated.
- Overflow: out_ready=0, send 3 frames with FRAME_DEPTH=2. Expect overflow=1 after the third, and the first two frames drained intact. Repeat with the pop and the 3rd capture in the same cycle and expect overflow=0.
- Reset mid-drain: assert rst low during the 2nd beat of a frame. Expect out_valid=0 asynchronously, busy=0, overflow=0, and clean operation of the next frame.

Source files
------------

// File: rtl/noc_result_drain.sv
// rtl/noc_result_drain.sv - buffers NoC result frames and drains their visible rows as stream beats
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   noc_result, noc_ready    flat result frame and its one-cycle capture strobe
//   visible                  per-PE visible mask captured alongside the frame
//   out_data/out_mask/out_row/out_last/out_valid/out_ready
//                            one row per beat, invisible lanes zeroed
//   overflow                 sticky flag: a frame arrived while the buffer was full
//   busy                     buffer non-empty or a beat pending
module noc_result_drain #(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_PEs_PER_ROW = 4,
    parameter int NUM_ROWS        = 4,
    parameter int FRAME_DEPTH     = 2,
    localparam int ROW_W          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] noc_result,
    input  logic                                          noc_ready,
    input  logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]            visible,
    output logic [NUM_PEs_PER_ROW*DATA_WIDTH-1:0]          out_data,
    output logic [NUM_PEs_PER_ROW-1:0]                     out_mask,
    output logic [ROW_W-1:0]                               out_row,
    output logic                                          out_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          overflow,
    output logic                                          busy
);

    localparam int BEAT_W  = NUM_PEs_PER_ROW * DATA_WIDTH;
    localparam int FRAME_W = NUM_ROWS * BEAT_W;
    localparam int VIS_W   = NUM_ROWS * NUM_PEs_PER_ROW;
    localparam int PTR_W   = $clog2(FRAME_DEPTH);
    localparam int CNT_W   = $clog2(FRAME_DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [FRAME_W-1:0] mem_res [FRAME_DEPTH];
    logic [VIS_W-1:0]   mem_vis [FRAME_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic [ROW_W-1:0] row;

    logic [FRAME_W-1:0]         head_res;
    logic [VIS_W-1:0]           head_vis;
    logic [BEAT_W-1:0]          row_data;
    logic [NUM_PEs_PER_ROW-1:0] row_mask;
    logic                       higher_vis;
    logic                       full;
    logic                       push;
    logic                       pop;
    logic                       drop;

    assign head_res = mem_res[rd_ptr];
    assign head_vis = mem_vis[rd_ptr];

    // Select the current row of the head frame and look ahead for any visible
    // bit in the rows above it; that look-ahead drives both out_last and the
    // early pop when the remainder of a frame is invisible.
    always_comb begin
        row_data   = '0;
        row_mask   = '0;
        higher_vis = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (ROW_W'(r) == row) begin
                row_data = head_res[r*BEAT_W +: BEAT_W];
                row_mask = head_vis[r*NUM_PEs_PER_ROW +: NUM_PEs_PER_ROW];
            end
            if (ROW_W'(r) > row) begin
                higher_vis = higher_vis | (|head_vis[r*NUM_PEs_PER_ROW +: NUM_PEs_PER_ROW]);
            end
        end
    end

    assign full = (count == CNT_W'(FRAME_DEPTH));

    // A frame leaves the buffer either when its last visible beat is accepted
    // or when the scan finds nothing left to send.
    assign pop = ((state == ST_SCAN) && (row_mask == '0) && !higher_vis) ||
                 ((state == ST_SEND) && out_ready && !higher_vis);

    // A pop in the same cycle frees the slot the incoming frame needs.
    assign push = noc_ready && (!full || pop);
    assign drop = noc_ready && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wr_ptr] <= noc_result;
            mem_vis[wr_ptr] <= visible;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= ST_IDLE;
            row      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_SCAN;
                        row   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (row_mask != '0) begin
                        state <= ST_SEND;
                    end else if (!higher_vis) begin
                        state <= ST_IDLE;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (!higher_vis) begin
                            state <= ST_IDLE;
                        end else begin
                            row   <= row + ROW_W'(1);
                            state <= ST_SCAN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Beat outputs derive from registered state and the untouched head slot,
    // so they hold steady across backpressure and read as zero outside SEND.
    assign out_valid = (state == ST_SEND);
    assign out_mask  = out_valid ? row_mask : '0;
    assign out_row   = out_valid ? row : '0;
    assign out_last  = out_valid && !higher_vis;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int p = 0; p < NUM_PEs_PER_ROW; p++) begin
                out_data[p*DATA_WIDTH +: DATA_WIDTH] =
                    row_mask[p] ? row_data[p*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
        end
    end

    assign busy = (count != '0) || out_valid;

endmodule

// File: tb/tb_noc_result_drain.sv
// tb/tb_noc_result_drain.sv - scoreboard testbench for noc_result_drain
module tb_noc_result_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] noc_result;
    logic         noc_ready;
    logic [15:0]  visible;
    logic [31:0]  out_data;
    logic [3:0]   out_mask;
    logic [1:0]   out_row;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         overflow;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] sb[$];
    logic        valid_seen;

    noc_result_drain dut (
        .clk        (clk),
        .rst        (rst),
        .noc_result (noc_result),
        .noc_ready  (noc_ready),
        .visible    (visible),
        .out_data   (out_data),
        .out_mask   (out_mask),
        .out_row    (out_row),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] mk_frame(input logic [7:0] base);
        logic [127:0] f;
        f = '0;
        for (int r = 0; r < 4; r++)
            for (int p = 0; p < 4; p++)
                f[(r*4+p)*8 +: 8] = base + 8'(16*r + p);
        return f;
    endfunction

    task automatic push_expected(input logic [127:0] res, input logic [15:0] vis);
        logic [3:0]  m;
        logic [31:0] d;
        logic        last;
        for (int r = 0; r < 4; r++) begin
            m = vis[r*4 +: 4];
            if (m != 4'h0) begin
                for (int p = 0; p < 4; p++)
                    d[p*8 +: 8] = m[p] ? res[(r*4+p)*8 +: 8] : 8'h00;
                last = ((vis >> ((r+1)*4)) == 16'h0);
                sb.push_back({25'b0, d, m, 2'(r), last});
            end
        end
    endtask

    // Called at posedge+1; strobes noc_ready for exactly one capture edge.
    task automatic send_frame(input logic [127:0] res, input logic [15:0] vis, input bit accept);
        noc_result = res;
        visible    = vis;
        noc_ready  = 1'b1;
        if (accept) push_expected(res, vis);
        @(posedge clk); #1;
        noc_ready  = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        check_eq("wait_valid", out_valid, 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !busy) break;
        end
        check_eq("drain_sb_left", sb.size(), 0);
        check_eq("drain_busy", busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) valid_seen = 1'b1;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0)
                check_eq("unexpected_beat", {25'b0, out_data, out_mask, out_row, out_last}, 64'hFFFF_FFFF_FFFF_FFFF);
            else
                check_eq("beat", {25'b0, out_data, out_mask, out_row, out_last}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] held;
        rst = 1'b0; noc_ready = 1'b0; out_ready = 1'b0;
        noc_result = '0; visible = '0; valid_seen = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_data", {out_data, out_mask, out_row, out_last}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single fully visible frame with latency check
        out_ready = 1'b1;
        send_frame(mk_frame(8'h00), 16'hFFFF, 1);
        check_eq("busy_after_capture", busy, 1);
        check_eq("lat_t0", out_valid, 0);
        @(posedge clk); #1;
        check_eq("lat_t1", out_valid, 0);
        @(posedge clk); #1;
        check_eq("lat_t2", out_valid, 1);
        check_eq("first_row", out_row, 0);
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_row == 2'd1) break;
            @(posedge clk); #1;
        end
        check_eq("row1_data", out_data, 32'h13121110);
        wait_drain(50);

        // Masked lanes and skipped rows
        send_frame(mk_frame(8'h40), 16'h0F0A, 1);
        wait_drain(50);

        // All-invisible frame is popped silently
        valid_seen = 1'b0;
        send_frame(mk_frame(8'h80), 16'h0000, 1);
        for (int i = 0; i < 5; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check_eq("zero_frame_popped", busy, 0);
        check_eq("zero_frame_no_beat", valid_seen, 0);
        send_frame(mk_frame(8'h90), 16'h8001, 1);
        wait_drain(50);

        // Backpressure holds the beat stable
        out_ready = 1'b0;
        send_frame(mk_frame(8'h20), 16'hF0F0, 1);
        wait_valid(10);
        held = {25'b0, out_data, out_mask, out_row, out_last};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", {25'b0, out_data, out_mask, out_row, out_last}, held);
        end
        out_ready = 1'b1;
        wait_drain(50);

        // Overflow: third back-to-back frame dropped
        out_ready = 1'b0;
        send_frame(mk_frame(8'hA0), 16'hFFFF, 1);
        send_frame(mk_frame(8'hB0), 16'h00FF, 1);
        send_frame(mk_frame(8'hC0), 16'hFFFF, 0);
        check_eq("overflow_set", overflow, 1);
        out_ready = 1'b1;
        wait_drain(80);
        check_eq("overflow_sticky", overflow, 1);
        rst = 1'b0;
        #1;
        check_eq("overflow_cleared", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Pop and capture in the same cycle while full
        out_ready = 1'b0;
        send_frame(mk_frame(8'h10), 16'h000F, 1);
        send_frame(mk_frame(8'h30), 16'h0F00, 1);
        wait_valid(10);
        check_eq("full_last_beat", out_last, 1);
        out_ready = 1'b1;
        send_frame(mk_frame(8'h50), 16'hFFFF, 1);
        check_eq("no_overflow_on_pop", overflow, 0);
        wait_drain(80);

        // Reset during the second beat of a frame
        out_ready = 1'b0;
        send_frame(mk_frame(8'h60), 16'hFFFF, 1);
        wait_valid(10);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_valid(10);
        check_eq("mid_row", out_row, 1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_overflow", overflow, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_frame(mk_frame(8'h70), 16'h1248, 1);
        wait_drain(50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
